// File: rtl/hamming_sec_reader_pkg.sv
// Shared constants, tables and types for the Hamming(12,8) SEC read path.
// Also provides the companion encoder used by writers of the protected memory.
package hamming_sec_reader_pkg;

  localparam int HSR_ADDR_W  = 4;
  localparam int HSR_CW_W    = 12;
  localparam int HSR_DATA_W  = 8;
  localparam int HSR_CNT_W   = 8;
  localparam int HSR_SYN_W   = 4;
  localparam int HSR_SYN_MAX = 12;

  // Positions are 1-based; bit index in the codeword is position - 1.
  localparam int HSR_PARITY_POS [HSR_SYN_W]  = '{1, 2, 4, 8};
  localparam int HSR_DATA_POS   [HSR_DATA_W] = '{3, 5, 6, 7, 9, 10, 11, 12};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_READ,
    ST_DECODE,
    ST_WB
  } state_e;

  function automatic logic [HSR_CW_W-1:0] hamming_encode(input logic [HSR_DATA_W-1:0] data);
    logic [HSR_CW_W-1:0] cw;
    logic                par;
    cw = '0;
    for (int i = 0; i < HSR_DATA_W; i++) cw[HSR_DATA_POS[i]-1] = data[i];
    for (int k = 0; k < HSR_SYN_W; k++) begin
      par = 1'b0;
      for (int p = 1; p <= HSR_CW_W; p++)
        if (((p >> k) & 1) != 0) par = par ^ cw[p-1];
      cw[HSR_PARITY_POS[k]-1] = par;
    end
    return cw;
  endfunction

endpackage

// File: rtl/hamming_sec_reader_decode.sv
// Combinational Hamming(12,8) SEC decoder: syndrome, single-bit correction, payload extraction.
module hamming_sec_decode
  import hamming_sec_reader_pkg::*;
(
  input  logic [HSR_CW_W-1:0]   cw_i,
  output logic [HSR_DATA_W-1:0] data_o,
  output logic [HSR_CW_W-1:0]   cw_o,
  output logic [HSR_SYN_W-1:0]  syndrome_o,
  output logic                  err_corr_o,
  output logic                  err_uncorr_o
);

  // NOTE: every output gets a value before any conditional logic, so no latches are inferred.
  always_comb begin
    syndrome_o = '0;
    for (int k = 0; k < HSR_SYN_W; k++)
      for (int p = 1; p <= HSR_CW_W; p++)
        if (((p >> k) & 1) != 0) syndrome_o[k] = syndrome_o[k] ^ cw_i[p-1];

    // Syndromes beyond the last codeword position cannot name a bit to flip.
    err_corr_o   = (syndrome_o != '0) && (int'(syndrome_o) <= HSR_SYN_MAX);
    err_uncorr_o = (syndrome_o != '0) && !err_corr_o;

    cw_o = cw_i;
    for (int p = 1; p <= HSR_CW_W; p++)
      if (err_corr_o && (int'(syndrome_o) == p)) cw_o[p-1] = ~cw_i[p-1];

    for (int i = 0; i < HSR_DATA_W; i++) data_o[i] = cw_o[HSR_DATA_POS[i]-1];
  end

endmodule

// File: rtl/hamming_sec_reader.sv
// Read-side controller for the Hamming SEC protected 16x12 memory.
// Define HAMMING_SCRUB_WRITEBACK_EN to write corrected codewords back (WB state).
module hamming_sec_reader
  import hamming_sec_reader_pkg::*;
#(
  parameter int ADDR_W = HSR_ADDR_W,
  parameter int CW_W   = HSR_CW_W,
  parameter int DATA_W = HSR_DATA_W,
  parameter int CNT_W  = HSR_CNT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_ready,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              err_corr,
  output logic              err_uncorr,
  output logic [3:0]        err_syndrome,
  output logic [CNT_W-1:0]  err_count,
  input  logic              err_clr,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [CW_W-1:0]   mem_rdata,
  output logic              mem_wr_en,
  output logic [CW_W-1:0]   mem_wr_data
);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   rd_data_q;
  logic                err_corr_q, err_uncorr_q;
  logic [3:0]          syn_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [CW_W-1:0]     corr_cw_q;

  logic [DATA_W-1:0]   dec_data;
  logic [CW_W-1:0]     dec_cw;
  logic [3:0]          dec_syn;
  logic                dec_corr, dec_uncorr;

  // The memory read is combinational, so the word is decoded while still in READ
  // and the registered results are already visible during DECODE.
  hamming_sec_decode u_decode (
    .cw_i         (mem_rdata),
    .data_o       (dec_data),
    .cw_o         (dec_cw),
    .syndrome_o   (dec_syn),
    .err_corr_o   (dec_corr),
    .err_uncorr_o (dec_uncorr)
  );

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:   if (rd_req) state_d = ST_READ;
      ST_READ:   state_d = ST_DECODE;
`ifdef HAMMING_SCRUB_WRITEBACK_EN
      ST_DECODE: state_d = err_corr_q ? ST_WB : ST_IDLE;
`else
      ST_DECODE: state_d = ST_IDLE;
`endif
      default:   state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    cnt_d = cnt_q;
    if (err_clr)
      cnt_d = '0;
    else if ((state_q == ST_DECODE) && err_corr_q && (cnt_q != {CNT_W{1'b1}}))
      cnt_d = cnt_q + 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mem_addr_q   <= '0;
      rd_data_q    <= '0;
      err_corr_q   <= 1'b0;
      err_uncorr_q <= 1'b0;
      syn_q        <= '0;
      cnt_q        <= '0;
      corr_cw_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if ((state_q == ST_IDLE) && rd_req) mem_addr_q <= rd_addr;
      if (state_q == ST_READ) begin
        rd_data_q    <= dec_data;
        err_corr_q   <= dec_corr;
        err_uncorr_q <= dec_uncorr;
        syn_q        <= dec_syn;
        corr_cw_q    <= dec_cw;
      end
    end
  end

  assign rd_ready     = (state_q == ST_IDLE);
  assign rd_valid     = (state_q == ST_DECODE);
  assign rd_data      = rd_data_q;
  assign err_corr     = err_corr_q;
  assign err_uncorr   = err_uncorr_q;
  assign err_syndrome = syn_q;
  assign err_count    = cnt_q;
  assign mem_addr     = mem_addr_q;

`ifdef HAMMING_SCRUB_WRITEBACK_EN
  assign mem_wr_en   = (state_q == ST_WB);
  assign mem_wr_data = corr_cw_q;
`else
  assign mem_wr_en   = 1'b0;
  assign mem_wr_data = '0;
`endif

endmodule

// File: tb/tb_hamming_sec_reader.sv
// Self-checking bench for hamming_sec_reader: directed cases, random words, saturation,
// reset mid-read and back-to-back requests against a position-XOR Hamming model.
module tb_hamming_sec_reader;

`ifdef HAMMING_SCRUB_WRITEBACK_EN
  localparam bit SCRUB = 1'b1;
`else
  localparam bit SCRUB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_req;
  logic [3:0]  rd_addr;
  logic        rd_ready, rd_valid;
  logic [7:0]  rd_data;
  logic        err_corr, err_uncorr;
  logic [3:0]  err_syndrome;
  logic [7:0]  err_count;
  logic        err_clr;
  logic [3:0]  mem_addr;
  logic [11:0] mem_rdata;
  logic        mem_wr_en;
  logic [11:0] mem_wr_data;

  logic [11:0] mem [16];
  int          total = 0;
  int          bad   = 0;
  int          m_cnt = 0;
  int          dpos [8] = '{3, 5, 6, 7, 9, 10, 11, 12};

  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr_en) mem[mem_addr] <= mem_wr_data;

  hamming_sec_reader dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ready     (rd_ready),
    .rd_valid     (rd_valid),
    .rd_data      (rd_data),
    .err_corr     (err_corr),
    .err_uncorr   (err_uncorr),
    .err_syndrome (err_syndrome),
    .err_count    (err_count),
    .err_clr      (err_clr),
    .mem_addr     (mem_addr),
    .mem_rdata    (mem_rdata),
    .mem_wr_en    (mem_wr_en),
    .mem_wr_data  (mem_wr_data)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
    end
  endtask

  // Syndrome of a Hamming word is the XOR of the positions of all set bits.
  function automatic int m_syn(input logic [11:0] w);
    int s = 0;
    for (int p = 1; p <= 12; p++) if (w[p-1]) s = s ^ p;
    return s;
  endfunction

  function automatic logic [11:0] m_encode(input logic [7:0] d);
    logic [11:0] w = '0;
    int s;
    for (int i = 0; i < 8; i++) w[dpos[i]-1] = d[i];
    s = m_syn(w);
    for (int k = 0; k < 4; k++) if (((s >> k) & 1) != 0) w[(1 << k) - 1] = 1'b1;
    return w;
  endfunction

  function automatic logic [11:0] m_fix(input logic [11:0] w);
    logic [11:0] c = w;
    int s = m_syn(w);
    if (s >= 1 && s <= 12) c[s-1] = ~c[s-1];
    return c;
  endfunction

  function automatic logic [7:0] m_data(input logic [11:0] w);
    logic [11:0] c = m_fix(w);
    logic [7:0]  d;
    for (int i = 0; i < 8; i++) d[i] = c[dpos[i]-1];
    return d;
  endfunction

  task automatic wait_ready();
    int n = 0;
    @(negedge clk);
    while (!rd_ready && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("ready_timeout", rd_ready, 1);
  endtask

  task automatic do_read(input logic [3:0] a, input bit clr_at_valid);
    logic [11:0] w;
    int          s, n;
    bit          seen;
    wait_ready();
    w       = mem[a];
    s       = m_syn(w);
    rd_req  = 1'b1;
    rd_addr = a;
    @(posedge clk);
    #1 rd_req = 1'b0;
    check("mem_addr", mem_addr, a);
    n = 0;
    seen = 0;
    while (n < 8 && !seen) begin
      @(negedge clk);
      n++;
      if (rd_valid) seen = 1;
    end
    check("latency", n, 2);
    check("rd_data", rd_data, m_data(w));
    check("syndrome", err_syndrome, s);
    check("err_corr", err_corr, (s >= 1 && s <= 12));
    check("err_uncorr", err_uncorr, (s >= 13));
    if (s >= 1 && s <= 12 && m_cnt < 255) m_cnt++;
    if (clr_at_valid) begin
      err_clr = 1'b1;
      m_cnt = 0;
    end
    @(negedge clk);
    err_clr = 1'b0;
    if (SCRUB && s >= 1 && s <= 12) begin
      check("wb_en", mem_wr_en, 1);
      check("wb_data", mem_wr_data, m_fix(w));
      check("wb_addr", mem_addr, a);
      check("wb_ready", rd_ready, 0);
      @(negedge clk);
    end
    check("valid_pulse", rd_valid, 0);
    check("wr_en_idle", mem_wr_en, 0);
    check("ready_after", rd_ready, 1);
    check("err_count", err_count, m_cnt);
  endtask

  initial begin
    int          last, idx, nval, cyc;
    bit          prev_corr;
    logic [11:0] q_w [$];
    logic [11:0] w;

    rst_n = 1'b0; rd_req = 1'b0; rd_addr = '0; err_clr = 1'b0;
    for (int i = 0; i < 16; i++) mem[i] = m_encode(8'(i * 17));
    #1;
    check("rst_ready", rd_ready, 1);
    check("rst_valid", rd_valid, 0);
    check("rst_data", rd_data, 0);
    check("rst_flags", {err_corr, err_uncorr, err_syndrome}, 0);
    check("rst_count", err_count, 0);
    check("rst_mem", {mem_addr, mem_wr_en, mem_wr_data}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    // Directed words
    mem[0] = 12'hF77; mem[1] = 12'h010; mem[2] = 12'h089;
    check("enc_ff", m_encode(8'hFF), 12'hF77);
    do_read(4'd0, 0);
    do_read(4'd1, 0);
    do_read(4'd2, 0);
    check("uncorr_kept", mem[2], 12'h089);

    // Random words: clean, single flip or arbitrary
    for (int t = 0; t < 40; t++) begin
      logic [3:0] a;
      int mode;
      a = 4'($urandom_range(15));
      w = m_encode(8'($urandom));
      mode = $urandom_range(2);
      if (mode == 1) w[$urandom_range(11)] ^= 1'b1;
      else if (mode == 2) w = 12'($urandom);
      mem[a] = w;
      do_read(a, 0);
    end

    // Saturation, then clear during a corrected DECODE
    for (int t = 0; t < 260; t++) begin
      mem[5] = m_encode(8'h5A) ^ 12'h040;
      do_read(4'd5, 0);
    end
    check("sat_count", err_count, 255);
    mem[5] = m_encode(8'h5A) ^ 12'h800;
    do_read(4'd5, 1);

    // Reset during READ abandons the request
    mem[3] = m_encode(8'h33) ^ 12'h001;
    wait_ready();
    rd_req = 1'b1; rd_addr = 4'd3;
    @(posedge clk);
    #1 rd_req = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_ready", rd_ready, 1);
    check("mid_rst_valid", rd_valid, 0);
    check("mid_rst_out", {rd_data, err_syndrome, mem_addr, err_corr, err_uncorr}, 0);
    m_cnt = 0;
    @(negedge clk);
    rst_n = 1'b1;
    nval = 0;
    repeat (4) begin
      @(negedge clk);
      if (rd_valid) nval++;
    end
    check("no_valid_after_rst", nval, 0);
    do_read(4'd3, 0);

    // Back-to-back with rd_req held high
    for (int i = 0; i < 4; i++) mem[i] = m_encode(8'($urandom));
    mem[1] ^= 12'h020;
    mem[2] ^= 12'h100;
    idx = 0; nval = 0; cyc = 0; last = 0; prev_corr = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      if (rd_valid) begin
        w = q_w.pop_front();
        check("b2b_data", rd_data, m_data(w));
        check("b2b_corr", err_corr, (m_syn(w) >= 1 && m_syn(w) <= 12));
        if (m_syn(w) >= 1 && m_syn(w) <= 12 && m_cnt < 255) m_cnt++;
        nval++;
      end
      if (rd_ready) begin
        if (idx < 4) begin
          if (idx > 0) check("b2b_spacing", cyc - last, (SCRUB && prev_corr) ? 4 : 3);
          rd_req = 1'b1;
          rd_addr = 4'(idx);
          q_w.push_back(mem[idx]);
          prev_corr = (m_syn(mem[idx]) >= 1 && m_syn(mem[idx]) <= 12);
          last = cyc;
          idx++;
        end else begin
          rd_req = 1'b0;
          if (nval == 4) break;
        end
      end
    end
    rd_req = 1'b0;
    check("b2b_valids", nval, 4);
    check("b2b_count", err_count, m_cnt);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/hamming_sec_reader.md
Name: hamming_sec_reader

Overview:
- Read-side controller for the Hamming SEC protected 16x12 codeword memory.
- Accepts read requests, drives the memory address, and captures the combinational read data.
- Decodes the Hamming(12,8) codeword: computes the syndrome, corrects single-bit errors and returns 8-bit data with status flags.
- Counts corrected errors; can optionally scrub (write back) corrected codewords.

Parameters:
- ADDR_W, 4, memory address width (16 entries)
- CW_W, 12, stored codeword width
- DATA_W, 8, decoded payload width
- CNT_W, 8, width of saturating corrected-error counter

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- rd_req  in  1  read request; accepted when rd_req && rd_ready
- rd_addr  in  4  address sampled on acceptance
- rd_ready  out  1  high only in IDLE
- rd_valid  out  1  one-cycle pulse, result valid
- rd_data  out  8  corrected payload
- err_corr  out  1  with rd_valid: single-bit error corrected
- err_uncorr  out  1  with rd_valid: syndrome 13..15, data passed uncorrected
- err_syndrome  out  4  with rd_valid: raw syndrome
- err_count  out  8  saturating count of corrected errors
- err_clr  in  1  synchronous clear of err_count
- mem_addr  out  4  memory address
- mem_rdata  in  12  memory combinational read data
- mem_wr_en  out  1  scrub write strobe
- mem_wr_data  out  12  scrub write codeword

Behaviour:
- Codeword layout: positions 1..12 map to bit index pos-1.
  - Parity bits at positions 1, 2, 4, 8.
  - d0..d7 at positions 3, 5, 6, 7, 9, 10, 11, 12.
  - p_k is the even parity over the positions with bit k set.
- Syndrome bit k is the XOR of all codeword positions with bit k set, parity bit included.
  - Syndrome 0: no error.
  - Syndrome 1..12: flip bit (syn-1); err_corr=1.
  - Syndrome 13..15: no flip; err_uncorr=1.
- Reset (async, rst_n=0):
  - FSM=IDLE, rd_ready=1.
  - rd_valid, err_corr, err_uncorr, mem_wr_en = 0.
  - rd_data, err_syndrome, mem_addr, mem_wr_data, err_count = 0.
  - Reset mid-operation abandons the request; no rd_valid is produced for it.
- FSM states: IDLE, READ, DECODE, plus WB when the feature is enabled.
  - IDLE: rd_ready=1. On accept, latch rd_addr into mem_addr and go to READ.
  - READ: capture mem_rdata into the codeword register; go to DECODE.
  - DECODE: register decode results; rd_valid=1 for exactly this cycle. Go to IDLE, or to WB if scrub is enabled and err_corr.
  - WB: see Optional Feature; then IDLE.
- Latency: acceptance at edge N gives rd_valid high during cycle N+2. Throughput is 1 request per 3 cycles, or 4 when scrubbing.
- No back-pressure on rd_valid. rd_data and the flags hold their values until the next DECODE.
- mem_addr holds the latched address from acceptance until the next acceptance.
- err_count increments on each DECODE with err_corr and saturates at 255.
  - err_clr has priority over a simultaneous increment: the result is 0.
  - err_uncorr events are not counted.
- rd_req outside IDLE is ignored.
- rd_req held high is re-accepted as soon as the FSM returns to IDLE.

Optional Feature:
- Macro: HAMMING_SCRUB_WRITEBACK_EN.
- Defined:
  - After a DECODE with err_corr, the FSM enters WB for one cycle.
  - In WB: mem_wr_en=1, mem_wr_data = corrected codeword, mem_addr unchanged, rd_ready=0.
  - Uncorrectable words are never written back.
- Undefined:
  - No WB state.
  - mem_wr_en and mem_wr_data are tied to 0.

Decomposition:
- Shared package holds:
  - Codeword and payload width constants.
  - Parity position constants (1, 2, 4, 8).
  - Data position table.
  - FSM state enum.
  - The syndrome range limit (12).
- One combinational sub-module, hamming_sec_decode, maps a 12-bit codeword to corrected data, corrected codeword, syndrome, err_corr and err_uncorr.
  - The companion encoder reuses the package tables.

Test Plan:
- mem word 0xF77 (data 0xFF, clean) -> rd_valid at N+2, rd_data=0xFF, syndrome=0, flags 0, err_count unchanged.
- mem word 0x010 (data 0x00, position 5 flipped) -> rd_data=0x00, syndrome=5, err_corr=1, err_count+1.
  - With the macro: mem_wr_en pulse at N+3 with mem_wr_data=0x000.
- mem word 0x089 (syndrome 1^4^8=13) -> err_uncorr=1, err_corr=0, rd_data taken unflipped.
  - No write-back; err_count unchanged.
- 256 corrected reads then one more -> err_count=255 and stays. err_clr during an err_corr DECODE -> 0.
- rst_n asserted during READ -> outputs reset immediately, no rd_valid; next request after release completes normally.
- Back-to-back rd_req held high, addrs 0..3 -> accepts spaced 3 cycles (4 with scrub on errors); rd_ready=0 except IDLE.
